// File: rtl/multi_dataflow_package.sv
// Shared types for the multi-dataflow wrapper; this slice carries the input-buffer types.
package multi_dataflow_package;

  localparam int IB_LEN_WIDTH = 16;

  typedef enum logic [1:0] {
    IB_IDLE,
    IB_RUN,
    IB_DRAIN,
    IB_DONE
  } in_buffer_state_t;

  typedef struct packed {
    logic                    start;
    logic [IB_LEN_WIDTH-1:0] len;
  } ctrl_in_buffer_t;

  typedef struct packed {
    logic                    busy;
    logic                    done;
    logic [IB_LEN_WIDTH-1:0] out_cnt;
  } flags_in_buffer_t;

endpackage

// File: rtl/multi_dataflow_in_buffer_fifo.sv
// First-word-fall-through FIFO for the input buffer; wrap-bit pointers, no FSM.
module multi_dataflow_in_buffer_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [STRB_WIDTH-1:0] strb_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [STRB_WIDTH-1:0] strb_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr_q, rd_ptr_q, fill;
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [STRB_WIDTH-1:0] strb_mem [DEPTH];
  logic                  do_push, do_pop;

  assign fill    = wr_ptr_q - rd_ptr_q;
  assign full_o  = (fill == (AW+1)'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = data_mem[rd_ptr_q[AW-1:0]];
  assign strb_o  = strb_mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is never reset; empty_o masks stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      data_mem[wr_ptr_q[AW-1:0]] <= data_i;
      strb_mem[wr_ptr_q[AW-1:0]] <= strb_i;
    end
  end

endmodule

// File: rtl/multi_dataflow_in_buffer.sv
// Framed input buffer: accepts exactly len words per job into a FIFO, forwards them, pulses done.
//   state    | meaning
//   IB_IDLE  | waiting for start_i, upstream blocked
//   IB_RUN   | accepting words until in_cnt reaches len
//   IB_DRAIN | upstream blocked, waiting for the last word to leave
//   IB_DONE  | one-cycle done pulse
module multi_dataflow_in_buffer
  import multi_dataflow_package::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  parameter  int LEN_WIDTH  = IB_LEN_WIDTH,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [STRB_WIDTH-1:0] in_strb_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [STRB_WIDTH-1:0] out_strb_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  out_cnt_o
);

  in_buffer_state_t     state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 soft_rst, push, pop, full, empty;

  assign soft_rst    = rst_i | clear_i;
  assign in_ready_o  = (state_q == IB_RUN) && !full;
  assign out_valid_o = !empty;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign busy_o      = (state_q == IB_RUN) || (state_q == IB_DRAIN);
  assign done_o      = (state_q == IB_DONE);
  assign out_cnt_o   = out_cnt_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = pop ? out_cnt_q + 1'b1 : out_cnt_q;
    case (state_q)
      IB_IDLE: begin
        if (start_i) begin
          len_d     = len_i;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (len_i == '0) ? IB_DONE : IB_RUN;
        end
      end
      IB_RUN: begin
        if (push) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_d == len_q) state_d = IB_DRAIN;
        end
      end
      // The last word is always still buffered on entry, so DONE is reached only via a pop here.
      IB_DRAIN: begin
        if (pop && (out_cnt_d == len_q)) state_d = IB_DONE;
      end
      IB_DONE: state_d = IB_IDLE;
      default: state_d = IB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state_q   <= IB_IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  multi_dataflow_in_buffer_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_WIDTH(STRB_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (soft_rst),
    .push_i (push),
    .data_i (in_data_i),
    .strb_i (in_strb_i),
    .pop_i  (pop),
    .data_o (out_data_o),
    .strb_o (out_strb_o),
    .full_o (full),
    .empty_o(empty)
  );

endmodule

// File: tb/tb_multi_dataflow_in_buffer.sv
// Bench for multi_dataflow_in_buffer: job table, hand-written corner sequences, random jobs.
module tb_multi_dataflow_in_buffer;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int LW    = 16;

  typedef logic [SW+DW-1:0] word_t;

  typedef struct {
    int len;
    int up_pct;
    int dn_pct;
    int base;
    int exp_words;
    int exp_dones;
  } job_vec_t;

  logic          clk_i = 1'b0;
  logic          rst_i, clear_i, start_i;
  logic [LW-1:0] len_i;
  logic [DW-1:0] in_data_i, out_data_o;
  logic [SW-1:0] in_strb_i, out_strb_o;
  logic          in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic          busy_o, done_o;
  logic [LW-1:0] out_cnt_o;

  always #5 clk_i = ~clk_i;

  multi_dataflow_in_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .LEN_WIDTH (LW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .in_data_i  (in_data_i),
    .in_strb_i  (in_strb_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .out_data_o (out_data_o),
    .out_strb_o (out_strb_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .out_cnt_o  (out_cnt_o)
  );

  word_t src[$];
  word_t exp_q[$];
  int    n_cmp = 0, n_bad = 0;
  int    cyc = 0;
  int    phase = 0;  // 0 idle, 1 run, 2 drain, 3 done
  int    m_len = 0, m_in = 0, m_out = 0;
  int    up_pct = 100, dn_pct = 100, stray_pct = 0;
  int    accepted, delivered, dones, busy_seen;
  int    start_cyc, done_cyc, first_acc_cyc, first_val_cyc;
  word_t first_word, last_word;
  job_vec_t jobs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic word_t mk(input logic [31:0] d);
    return {d[3:0] ^ 4'h5, d};
  endfunction

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) src.push_back(mk(32'(base + i)));
  endtask

  task automatic drive();
    in_valid_i  = (src.size() > 0) && ($urandom_range(99) < up_pct);
    if (src.size() > 0) {in_strb_i, in_data_i} = src[0];
    else {in_strb_i, in_data_i} = '0;
    out_ready_i = ($urandom_range(99) < dn_pct);
    start_i = 1'b0;
    if (stray_pct > 0 && phase != 0 && $urandom_range(99) < stray_pct) begin
      start_i = 1'b1;
      len_i   = LW'($urandom_range(1, 64));
    end
  endtask

  task automatic tick();
    bit    pf, qf, rs;
    word_t w;
    pf = in_valid_i && in_ready_o;
    qf = out_valid_o && out_ready_i;
    rs = rst_i || clear_i;
    w  = {out_strb_o, out_data_o};
    @(posedge clk_i);
    #1;
    cyc++;
    if (rs) begin
      phase = 0; m_in = 0; m_out = 0; m_len = 0;
      exp_q.delete();
    end else begin
      if (qf) begin
        if (exp_q.size() == 0) chk("pop_while_empty", 1, 0);
        else begin
          chk("out_word", w, exp_q[0]);
          void'(exp_q.pop_front());
        end
        delivered++;
        if (delivered == 1) first_word = w;
        last_word = w;
      end
      if (pf) begin
        exp_q.push_back(src.pop_front());
        accepted++;
        if (accepted == 1) first_acc_cyc = cyc;
      end
      case (phase)
        0: if (start_i) begin
             m_len = int'(len_i); m_in = 0; m_out = 0;
             phase = (len_i == 0) ? 3 : 1;
           end
        1: begin
             if (pf) begin m_in++; if (m_in == m_len) phase = 2; end
             if (qf) m_out++;
           end
        2: if (qf) begin m_out++; if (m_out == m_len) phase = 3; end
        default: phase = 0;
      endcase
    end
    chk("busy", busy_o, (phase == 1 || phase == 2));
    chk("done", done_o, (phase == 3));
    chk("in_ready", in_ready_o, (phase == 1 && exp_q.size() < DEPTH));
    chk("out_valid", out_valid_o, (exp_q.size() != 0));
    chk("out_cnt", out_cnt_o, m_out);
    if (busy_o) busy_seen++;
    if (out_valid_o && first_val_cyc < 0) first_val_cyc = cyc;
    if (done_o) begin
      dones++;
      done_cyc = cyc;
      chk("out_cnt_at_done", out_cnt_o, m_len);
    end
    drive();
  endtask

  task automatic start_job(input int len);
    int guard = 0;
    while (phase != 0 && guard < 10) begin tick(); guard++; end
    drive();
    accepted = 0; delivered = 0; dones = 0; busy_seen = 0;
    first_acc_cyc = -1; first_val_cyc = -1; done_cyc = -1;
    start_i = 1'b1;
    len_i   = LW'(len);
    tick();
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (dones == 0 && n < budget) begin tick(); n++; end
    if (dones == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready_o, 0);
    chk({tag, "_out_valid"}, out_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_out_cnt"}, out_cnt_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    jobs[0] = '{len: 1,  up_pct: 100, dn_pct: 100, base: 'h1000, exp_words: 1,  exp_dones: 1};
    jobs[1] = '{len: 5,  up_pct: 50,  dn_pct: 100, base: 'h2000, exp_words: 5,  exp_dones: 1};
    jobs[2] = '{len: 12, up_pct: 100, dn_pct: 30,  base: 'h3000, exp_words: 12, exp_dones: 1};
    jobs[3] = '{len: 4,  up_pct: 60,  dn_pct: 60,  base: 'h4000, exp_words: 4,  exp_dones: 1};

    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; in_strb_i = '0; out_ready_i = 1'b0;
    up_pct = 100; dn_pct = 100;
    repeat (2) tick();
    rst_i = 1'b0;
    check_reset_outputs("reset");

    // basic back-to-back job
    load(1, 8);
    start_job(8);
    wait_done(100);
    chk("basic_delivered", delivered, 8);
    chk("basic_first_acc_lat", first_acc_cyc - start_cyc, 1);
    chk("basic_first_val_lat", first_val_cyc - first_acc_cyc, 0);
    chk("basic_done_lat", done_cyc - start_cyc, 9);
    chk("basic_first_word", first_word, mk(1));
    chk("basic_last_word", last_word, mk(8));
    repeat (3) tick();
    chk("basic_single_done", dones, 1);

    foreach (jobs[j]) begin
      src.delete();
      up_pct = jobs[j].up_pct; dn_pct = jobs[j].dn_pct;
      load(jobs[j].base, jobs[j].len + 2);
      start_job(jobs[j].len);
      wait_done(500);
      repeat (2) tick();
      chk("tbl_words", delivered, jobs[j].exp_words);
      chk("tbl_dones", dones, jobs[j].exp_dones);
      chk("tbl_last_word", last_word, mk(32'(jobs[j].base + jobs[j].len - 1)));
      chk("tbl_leftover", src.size(), 2);
    end

    // backpressure: only DEPTH words fit while the engine stalls
    src.delete();
    load('h100, 10);
    up_pct = 100; dn_pct = 0;
    start_job(10);
    repeat (20) tick();
    chk("bp_accepted", accepted, DEPTH);
    chk("bp_in_ready", in_ready_o, 0);
    chk("bp_delivered_stalled", delivered, 0);
    dn_pct = 100;
    wait_done(100);
    repeat (2) tick();
    chk("bp_delivered", delivered, 10);
    chk("bp_dones", dones, 1);
    chk("bp_last_word", last_word, mk('h109));

    // zero length: straight to DONE, nothing accepted
    src.delete();
    load('h200, 3);
    start_job(0);
    chk("zero_done_lat", done_cyc - start_cyc, 0);
    repeat (4) tick();
    chk("zero_accepted", accepted, 0);
    chk("zero_dones", dones, 1);
    chk("zero_busy_seen", busy_seen, 0);
    chk("zero_pending", src.size(), 3);

    // overrun guard: extra words wait for the next job
    src.delete();
    load('h301, 5);
    start_job(3);
    wait_done(100);
    repeat (3) tick();
    chk("ovr_accepted", accepted, 3);
    chk("ovr_pending", src.size(), 2);
    chk("ovr_last_word", last_word, mk('h303));
    start_job(2);
    wait_done(100);
    chk("ovr2_delivered", delivered, 2);
    chk("ovr2_first_word", first_word, mk('h304));
    chk("ovr2_last_word", last_word, mk('h305));

    // abort via rst_i mid-job, then via clear_i
    for (int k = 0; k < 2; k++) begin
      int guard = 0;
      src.delete();
      load('h400, 16);
      dn_pct = 50;
      start_job(16);
      while (accepted < 6 && guard < 200) begin tick(); guard++; end
      chk("abort_reached_6", accepted >= 6, 1);
      in_valid_i = 1'b0; out_ready_i = 1'b0; start_i = 1'b0;
      if (k == 0) rst_i = 1'b1; else clear_i = 1'b1;
      tick();
      rst_i = 1'b0; clear_i = 1'b0;
      check_reset_outputs(k == 0 ? "abort_rst" : "abort_clr");
      repeat (5) tick();
      chk("abort_no_done", dones, 0);
      src.delete();
      load('h500 + 16 * k, 2);
      dn_pct = 100;
      start_job(2);
      wait_done(100);
      chk("abort_new_delivered", delivered, 2);
      chk("abort_new_first", first_word, mk(32'('h500 + 16 * k)));
    end

    // random jobs with stray starts while busy
    begin
      int t0 = cyc;
      int njobs = 0;
      stray_pct = 5;
      while (cyc - t0 < 10000) begin
        int len = $urandom_range(1, 64);
        src.delete();
        up_pct = $urandom_range(30, 100);
        dn_pct = $urandom_range(30, 100);
        load('h10000 * (njobs + 1), len + $urandom_range(0, 3));
        start_job(len);
        wait_done(2000);
        chk("rand_one_done", dones, 1);
        chk("rand_delivered", delivered, len);
        chk("rand_last_word", last_word, mk(32'('h10000 * (njobs + 1) + len - 1)));
        njobs++;
      end
      stray_pct = 0;
      repeat (3) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
